// File: rtl/window_stream_gen.sv
// -----------------------------------------------------------------------------
// window_stream_gen
//   Streams every WIN x WIN window (stride 1, raster order) of an IMG_H x IMG_W
//   image held in word-addressed memory. Each band of WIN image rows is read
//   one word column at a time into WIN row buffers. A window is presented
//   whenever at least WIN pixels are buffered. Each accepted window shifts the
//   buffers left by one pixel.
//
//   Optional feature macro: WINDOW_ABORT_EN (adds i_abort; frame abort).
//
// Ports
//   clk          clock
//   rst_n        asynchronous active-low reset
//   i_start      begin a frame (sampled only in IDLE)
//   i_abort      abort current frame (only with WINDOW_ABORT_EN)
//   o_ack        1-cycle pulse: start accepted
//   o_rd_en      memory read request
//   o_rd_row     pixel row of the request
//   o_rd_col     word column of the request
//   i_rd_data    read data, valid one cycle after o_rd_en; MSB byte = leftmost
//   o_win_valid  window data / coordinates valid
//   i_win_ready  consumer accepts the window
//   o_win_data   pixel (r,c) at bits [(r*WIN+c)*PIX_W +: PIX_W]
//   o_win_row    top row of the presented window
//   o_win_col    left column of the presented window
//   o_busy       high from the ack cycle through the done cycle
//   o_done       1-cycle pulse after the final window (or an abort)
// -----------------------------------------------------------------------------
module window_stream_gen #(
  parameter int IMG_W    = 80,
  parameter int IMG_H    = 80,
  parameter int WIN      = 16,
  parameter int PIX_W    = 8,
  parameter int WORD_PIX = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   i_start,
`ifdef WINDOW_ABORT_EN
  input  logic                                   i_abort,
`endif
  output logic                                   o_ack,
  output logic                                   o_rd_en,
  output logic [$clog2(IMG_H)-1:0]               o_rd_row,
  output logic [$clog2(IMG_W/WORD_PIX)-1:0]      o_rd_col,
  input  logic [WORD_PIX*PIX_W-1:0]              i_rd_data,
  output logic                                   o_win_valid,
  input  logic                                   i_win_ready,
  output logic [WIN*WIN*PIX_W-1:0]               o_win_data,
  output logic [$clog2(IMG_H)-1:0]               o_win_row,
  output logic [$clog2(IMG_W)-1:0]               o_win_col,
  output logic                                   o_busy,
  output logic                                   o_done
);

  localparam int NWORDS    = IMG_W / WORD_PIX;
  localparam int DEPTH     = WIN + WORD_PIX - 1;
  localparam int ROW_W     = $clog2(IMG_H);
  localparam int COL_W     = $clog2(IMG_W);
  localparam int RDC_W     = $clog2(NWORDS);
  localparam int WC_W      = $clog2(NWORDS + 1);   // wcol reaches NWORDS
  localparam int CNT_W     = $clog2(DEPTH + 1);
  localparam int LC_W      = $clog2(WIN + 1);
  localparam int BAND_LAST = IMG_H - WIN;

  localparam logic [CNT_W-1:0] WIN_C = CNT_W'(WIN);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ACK  = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_EMIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]       r_state;
  logic [ROW_W-1:0] r_band;
  logic [WC_W-1:0]  r_wcol;
  logic [CNT_W-1:0] r_cnt;
  logic [LC_W-1:0]  r_lcnt;
  logic             r_ack;
  logic             r_busy;
  logic             r_done;
  logic             r_rd_en;
  logic [ROW_W-1:0] r_rd_row;
  logic [RDC_W-1:0] r_rd_col;
  logic             r_win_valid;
  logic [COL_W-1:0] r_win_col;
  logic [PIX_W-1:0] r_buf [WIN][DEPTH];

  logic             w_abort;
  logic             w_accept;
  logic             w_clear;
  logic             w_load_wr;
  logic [CNT_W-1:0] w_cnt_add;
  logic [CNT_W-1:0] w_cnt_dec;
  logic             w_stay_emit;
  logic             w_next_word;
  logic             w_next_band;
  logic             w_finish;

`ifdef WINDOW_ABORT_EN
  assign w_abort = i_abort && ((r_state == S_LOAD) || (r_state == S_EMIT));
`else
  assign w_abort = 1'b0;
`endif

  assign w_accept  = (r_state == S_EMIT) && i_win_ready;
  assign w_load_wr = (r_state == S_LOAD) && (r_lcnt != {LC_W{1'b0}});
  assign w_cnt_add = r_cnt + CNT_W'(WORD_PIX);
  assign w_cnt_dec = r_cnt - CNT_W'(1);
  assign w_clear   = ((r_state == S_IDLE) && i_start) || (w_accept && w_next_band) || w_abort;

  // Decide where an accepted window leads (evaluated on post-shift count)
  always_comb begin
    w_stay_emit = 1'b0;
    w_next_word = 1'b0;
    w_next_band = 1'b0;
    w_finish    = 1'b0;
    if (w_accept) begin
      if (w_cnt_dec >= WIN_C) begin
        w_stay_emit = 1'b1;
      end else if (r_wcol < WC_W'(NWORDS)) begin
        w_next_word = 1'b1;
      end else if (r_band < ROW_W'(BAND_LAST)) begin
        w_next_band = 1'b1;
      end else begin
        w_finish = 1'b1;
      end
    end else begin
      w_stay_emit = 1'b0;
    end
  end

  // Control FSM, counters and all registered handshake/read outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_band      <= '0;
      r_wcol      <= '0;
      r_cnt       <= '0;
      r_lcnt      <= '0;
      r_ack       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_row    <= '0;
      r_rd_col    <= '0;
      r_win_valid <= 1'b0;
      r_win_col   <= '0;
    end else begin
      r_ack  <= 1'b0;
      r_done <= 1'b0;
      if (w_abort) begin
        r_state     <= S_DONE;
        r_done      <= 1'b1;
        r_win_valid <= 1'b0;
        r_rd_en     <= 1'b0;
        r_cnt       <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_state   <= S_ACK;
              r_ack     <= 1'b1;
              r_busy    <= 1'b1;
              r_band    <= '0;
              r_wcol    <= '0;
              r_cnt     <= '0;
              r_win_col <= '0;
            end
          end
          S_ACK: begin
            r_state  <= S_LOAD;
            r_lcnt   <= '0;
            r_rd_en  <= 1'b1;
            r_rd_row <= r_band;
            r_rd_col <= RDC_W'(r_wcol);
          end
          S_LOAD: begin
            if (r_lcnt == LC_W'(WIN)) begin
              // last returned word of this column has just been appended
              r_cnt  <= w_cnt_add;
              r_wcol <= r_wcol + WC_W'(1);
              r_lcnt <= '0;
              if (w_cnt_add >= WIN_C) begin
                r_state     <= S_EMIT;
                r_win_valid <= 1'b1;
              end else begin
                r_rd_en  <= 1'b1;
                r_rd_row <= r_band;
                r_rd_col <= RDC_W'(r_wcol + WC_W'(1));
              end
            end else begin
              r_lcnt <= r_lcnt + LC_W'(1);
              if (r_lcnt == LC_W'(WIN - 1)) begin
                r_rd_en <= 1'b0;
              end else begin
                r_rd_row <= r_rd_row + ROW_W'(1);
              end
            end
          end
          S_EMIT: begin
            if (w_accept) begin
              r_cnt     <= w_cnt_dec;
              r_win_col <= r_win_col + COL_W'(1);
              if (w_next_word) begin
                r_state     <= S_LOAD;
                r_win_valid <= 1'b0;
                r_lcnt      <= '0;
                r_rd_en     <= 1'b1;
                r_rd_row    <= r_band;
                r_rd_col    <= RDC_W'(r_wcol);
              end else if (w_next_band) begin
                r_state     <= S_LOAD;
                r_win_valid <= 1'b0;
                r_band      <= r_band + ROW_W'(1);
                r_wcol      <= '0;
                r_cnt       <= '0;
                r_win_col   <= '0;
                r_lcnt      <= '0;
                r_rd_en     <= 1'b1;
                r_rd_row    <= r_band + ROW_W'(1);
                r_rd_col    <= '0;
              end else if (w_finish) begin
                r_state     <= S_DONE;
                r_win_valid <= 1'b0;
                r_done      <= 1'b1;
              end
            end
          end
          S_DONE: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Row buffers: clear on frame/band start or abort, shift on accept, append in LOAD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < WIN; r++) begin
        for (int j = 0; j < DEPTH; j++) begin
          r_buf[r][j] <= '0;
        end
      end
    end else if (w_clear) begin
      for (int r = 0; r < WIN; r++) begin
        for (int j = 0; j < DEPTH; j++) begin
          r_buf[r][j] <= '0;
        end
      end
    end else if (w_accept) begin
      for (int r = 0; r < WIN; r++) begin
        for (int j = 0; j < DEPTH - 1; j++) begin
          r_buf[r][j] <= r_buf[r][j+1];
        end
        r_buf[r][DEPTH-1] <= '0;
      end
    end else if (w_load_wr) begin
      // word returned in LOAD cycle i belongs to buffer i-1, written at the tail
      for (int r = 0; r < WIN; r++) begin
        for (int j = 0; j < DEPTH; j++) begin
          for (int k = 0; k < WORD_PIX; k++) begin
            if ((r_lcnt == LC_W'(r + 1)) && ((r_cnt + CNT_W'(k)) == CNT_W'(j))) begin
              r_buf[r][j] <= i_rd_data[(WORD_PIX-1-k)*PIX_W +: PIX_W];
            end
          end
        end
      end
    end
  end

  for (genvar gr = 0; gr < WIN; gr++) begin : g_row
    for (genvar gc = 0; gc < WIN; gc++) begin : g_col
      assign o_win_data[(gr*WIN+gc)*PIX_W +: PIX_W] = r_buf[gr][gc];
    end
  end

  assign o_ack       = r_ack;
  assign o_rd_en     = r_rd_en;
  assign o_rd_row    = r_rd_row;
  assign o_rd_col    = r_rd_col;
  assign o_win_valid = r_win_valid;
  assign o_win_row   = r_band;
  assign o_win_col   = r_win_col;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_window_stream_gen.sv
module tb_window_stream_gen;

  localparam int IW = 80, IH = 80, W = 16;
  localparam int SW = 8, SH = 4, SWIN = 4;

  logic clk;
  logic rst_n;

  logic          b_start, b_ack, b_rd_en, b_win_valid, b_win_ready, b_busy, b_done;
  logic [6:0]    b_rd_row, b_win_row, b_win_col;
  logic [4:0]    b_rd_col;
  logic [31:0]   b_rd_data;
  logic [2047:0] b_win_data;
  logic          b_abort;

  logic          s_start, s_ack, s_rd_en, s_win_valid, s_win_ready, s_busy, s_done;
  logic [1:0]    s_rd_row, s_win_row;
  logic [0:0]    s_rd_col;
  logic [2:0]    s_win_col;
  logic [31:0]   s_rd_data;
  logic [127:0]  s_win_data;

  int n_tests = 0;
  int n_fail  = 0;

  window_stream_gen dut (
    .clk(clk), .rst_n(rst_n), .i_start(b_start),
`ifdef WINDOW_ABORT_EN
    .i_abort(b_abort),
`endif
    .o_ack(b_ack), .o_rd_en(b_rd_en), .o_rd_row(b_rd_row), .o_rd_col(b_rd_col),
    .i_rd_data(b_rd_data), .o_win_valid(b_win_valid), .i_win_ready(b_win_ready),
    .o_win_data(b_win_data), .o_win_row(b_win_row), .o_win_col(b_win_col),
    .o_busy(b_busy), .o_done(b_done)
  );

  window_stream_gen #(.IMG_W(SW), .IMG_H(SH), .WIN(SWIN), .PIX_W(8), .WORD_PIX(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .i_start(s_start),
`ifdef WINDOW_ABORT_EN
    .i_abort(1'b0),
`endif
    .o_ack(s_ack), .o_rd_en(s_rd_en), .o_rd_row(s_rd_row), .o_rd_col(s_rd_col),
    .i_rd_data(s_rd_data), .o_win_valid(s_win_valid), .i_win_ready(s_win_ready),
    .o_win_data(s_win_data), .o_win_row(s_win_row), .o_win_col(s_win_col),
    .o_busy(s_busy), .o_done(s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pix_b(input int r, input int c);
    return 8'((r * IW + c) & 255);
  endfunction

  function automatic logic [7:0] pix_s(input int r, input int c);
    return 8'((r * SW + c) & 255);
  endfunction

  // Ramp-image memories: data returned one cycle after the request, MSB byte leftmost
  always @(posedge clk) begin
    logic [31:0] wb, ws;
    for (int k = 0; k < 4; k++) begin
      wb[(3-k)*8 +: 8] = pix_b(int'(b_rd_row), int'(b_rd_col) * 4 + k);
      ws[(3-k)*8 +: 8] = pix_s(int'(s_rd_row), int'(s_rd_col) * 4 + k);
    end
    b_rd_data <= b_rd_en ? wb : 32'h0;
    s_rd_data <= s_rd_en ? ws : 32'h0;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One frame on the 80x80 instance; optionally stop while window (sr,sc) is presented
  task automatic run_big(input int mode, input bit stop_en, input int sr, input int sc);
    int cyc, t_first, nwin, er, ec;
    bit got_ack, got_done, stopped, watch_rd, watch_win;
    logic [127:0] exp_row;
    got_ack = 1'b0; got_done = 1'b0; stopped = 1'b0; watch_rd = 1'b0; watch_win = 1'b0;
    @(negedge clk);
    b_start = 1'b1;
    b_win_ready = 1'b0;
    for (int i = 0; i < 8 && !got_ack; i++) begin
      @(negedge clk);
      if (b_ack) got_ack = 1'b1;
    end
    b_start = 1'b0;
    check("big_ack_seen", 128'(got_ack), 128'(1));
    check("big_busy_at_ack", 128'(b_busy), 128'(1));
    cyc = 0; t_first = -1; er = 0; ec = 0; nwin = 0;
    b_win_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    while (got_ack && !got_done && !stopped && cyc < 45000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("big_ack_pulse", 128'(b_ack), 128'(0));
      if (watch_rd && b_rd_en) begin
        check("band_edge_rd_row", 128'(b_rd_row), 128'(1));
        check("band_edge_rd_col", 128'(b_rd_col), 128'(0));
        watch_rd = 1'b0;
      end
      if (b_win_valid) begin
        if (t_first < 0) t_first = cyc;
        if (watch_win) begin
          check("band_edge_win_row", 128'(b_win_row), 128'(1));
          check("band_edge_win_col", 128'(b_win_col), 128'(0));
          watch_win = 1'b0;
        end
        check("big_win_row", 128'(b_win_row), 128'(er));
        check("big_win_col", 128'(b_win_col), 128'(ec));
        for (int r = 0; r < W; r++) begin
          for (int c = 0; c < W; c++) exp_row[c*8 +: 8] = pix_b(er + r, ec + c);
          check("big_win_data", b_win_data[r*128 +: 128], exp_row);
        end
        if (stop_en && er == sr && ec == sc) stopped = 1'b1;
      end
      if (b_done) begin
        got_done = 1'b1;
        check("big_done_count", 128'(nwin), 128'((IW - W + 1) * (IH - W + 1)));
        check("big_busy_at_done", 128'(b_busy), 128'(1));
      end
      if (!stopped) begin
        b_win_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        if (b_win_valid && b_win_ready) begin
          if (er == 0 && ec == IW - W) begin
            watch_rd = 1'b1;
            watch_win = 1'b1;
          end
          nwin++;
          ec++;
          if (ec > IW - W) begin
            ec = 0;
            er++;
          end
        end
      end
    end
    check("big_first_valid_cycle", 128'(t_first), 128'(69));
    if (stop_en) begin
      check("big_stop_reached", 128'(stopped), 128'(1));
    end else begin
      check("big_done_seen", 128'(got_done), 128'(1));
      @(negedge clk);
      check("big_done_pulse", 128'(b_done), 128'(0));
      check("big_busy_after", 128'(b_busy), 128'(0));
      check("big_valid_after", 128'(b_win_valid), 128'(0));
    end
  endtask

  // One frame on the 8x4 / WIN=4 instance
  task automatic run_small(input int pass);
    int cyc, t_first, nwin;
    bit got_ack, got_done;
    logic [127:0] exp_w;
    got_ack = 1'b0; got_done = 1'b0;
    @(negedge clk);
    s_start = 1'b1;
    for (int i = 0; i < 8 && !got_ack; i++) begin
      @(negedge clk);
      if (s_ack) got_ack = 1'b1;
    end
    s_start = 1'b0;
    s_win_ready = 1'b1;
    check("small_ack_seen", 128'(got_ack), 128'(1));
    cyc = 0; t_first = -1; nwin = 0;
    while (got_ack && !got_done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (s_win_valid) begin
        if (t_first < 0) t_first = cyc;
        check("small_win_row", 128'(s_win_row), 128'(0));
        check("small_win_col", 128'(s_win_col), 128'(nwin));
        for (int r = 0; r < SWIN; r++)
          for (int c = 0; c < SWIN; c++) exp_w[(r*SWIN+c)*8 +: 8] = pix_s(r, nwin + c);
        check("small_win_data", s_win_data, exp_w);
        nwin++;
      end
      if (s_done) begin
        got_done = 1'b1;
        check("small_done_count", 128'(nwin), 128'(5));
      end
    end
    check("small_done_seen", 128'(got_done), 128'(1));
    check("small_first_valid_cycle", 128'(t_first), 128'(6));
    @(negedge clk);
    check("small_busy_after", 128'(s_busy), 128'(0));
    if (pass > 1) check("small_rerun_ack_low", 128'(s_ack), 128'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    b_start = 1'b0; b_win_ready = 1'b0; b_abort = 1'b0;
    s_start = 1'b0; s_win_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack", 128'(b_ack), 128'(0));
    check("rst_busy", 128'(b_busy), 128'(0));
    check("rst_valid", 128'(b_win_valid), 128'(0));
    check("rst_rd_en", 128'(b_rd_en), 128'(0));
    check("rst_done", 128'(b_done), 128'(0));
    check("rst_data_zero", 128'(|b_win_data), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run_big(0, 1'b0, 0, 0);
    run_big(1, 1'b0, 0, 0);
    run_small(1);
    run_small(2);

`ifdef WINDOW_ABORT_EN
    run_big(0, 1'b1, 3, 7);
    b_abort = 1'b1;
    @(negedge clk);
    b_abort = 1'b0;
    check("abort_done", 128'(b_done), 128'(1));
    check("abort_valid_low", 128'(b_win_valid), 128'(0));
    @(negedge clk);
    check("abort_busy_low", 128'(b_busy), 128'(0));
    check("abort_done_pulse", 128'(b_done), 128'(0));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("abort_no_valid", 128'(b_win_valid), 128'(0));
    end
`endif

    run_big(0, 1'b1, 10, 20);
    rst_n = 1'b0;
    b_win_ready = 1'b0;
    @(negedge clk);
    check("midrst_ack", 128'(b_ack), 128'(0));
    check("midrst_rd_en", 128'(b_rd_en), 128'(0));
    check("midrst_rd_row", 128'(b_rd_row), 128'(0));
    check("midrst_rd_col", 128'(b_rd_col), 128'(0));
    check("midrst_valid", 128'(b_win_valid), 128'(0));
    check("midrst_data_zero", 128'(|b_win_data), 128'(0));
    check("midrst_win_row", 128'(b_win_row), 128'(0));
    check("midrst_win_col", 128'(b_win_col), 128'(0));
    check("midrst_busy", 128'(b_busy), 128'(0));
    check("midrst_done", 128'(b_done), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    run_big(0, 1'b1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
